// File: rtl/feature_pool.sv
// feature_pool: 2x2 stride-2 max/average pooling over a raster pixel stream,
// N_CH channels in parallel, one pixel per cycle, gaps allowed anywhere.

// One channel: horizontal pair reduction, line buffer of even-row partials,
// and the registered window result.
module feature_pool_lane #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 14,
  parameter int LB_AW  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_even,
  input  logic                     pair,
  input  logic                     odd_row,
  input  logic                     avg,
  input  logic [LB_AW-1:0]         lb_idx,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y
);
  // Two guard bits hold an exact four-sample sum.
  localparam int PW = DATA_W + 2;

  logic signed [DATA_W-1:0] hold;
  logic signed [PW-1:0]     lb [OUT_W];
  logic signed [PW-1:0]     hx, xx, ps, lbv, ws, res;

  // Pair partial (even col + odd col), then window = line-buffer partial + pair partial.
  always_comb begin
    hx  = {{2{hold[DATA_W-1]}}, hold};
    xx  = {{2{x[DATA_W-1]}}, x};
    ps  = avg ? (hx + xx) : ((hx > xx) ? hx : xx);
    lbv = lb[lb_idx];
    ws  = avg ? (lbv + ps) : ((lbv > ps) ? lbv : ps);
    res = avg ? (ws >>> 2) : ws;
  end

  // Even-column sample waits here for its odd-column partner.
  always_ff @(posedge clk) begin
    if (ld_even) hold <= x;
  end

  // Even rows always overwrite before odd rows read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (pair && !odd_row) lb[lb_idx] <= ps;
  end

  // Result register; holds between windows.
  always_ff @(posedge clk) begin
    if (rst)                  y <= '0;
    else if (pair && odd_row) y <= DATA_W'(res);
  end
endmodule

module feature_pool #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 6,
  parameter int IN_W   = 28,
  parameter int IN_H   = 28
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_avg_mode,
  input  logic                     i_feature_valid,
  input  logic signed [DATA_W-1:0] i_features [0:N_CH-1],
  output logic                     o_feature_valid,
  output logic signed [DATA_W-1:0] o_features [0:N_CH-1],
  output logic                     o_frame_done
);
  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  localparam int CW    = $clog2(IN_W);
  localparam int RW    = $clog2(IN_H);
  localparam int LB_AW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             mode_q, avg, first, col_in, row_in, ld_even, pair, emit, last_win;
  logic [LB_AW-1:0] lb_idx;

  // Beat decode: pixel (0,0) uses the live mode pin, the rest of the frame the latched one.
  always_comb begin
    first    = (row == '0) && (col == '0);
    avg      = first ? i_avg_mode : mode_q;
    col_in   = !(((IN_W % 2) == 1) && (col == CW'(IN_W - 1)));
    row_in   = !(((IN_H % 2) == 1) && (row == RW'(IN_H - 1)));
    lb_idx   = LB_AW'(col >> 1);
    ld_even  = i_feature_valid && !col[0];
    pair     = i_feature_valid && col[0] && col_in && row_in;
    emit     = pair && row[0];
    last_win = (row == RW'(2 * OUT_H - 1)) && (col == CW'(2 * OUT_W - 1));
  end

  // Raster position counters, advance on valid beats only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else if (i_feature_valid) begin
      if (col == CW'(IN_W - 1)) begin
        col <= '0;
        row <= (row == RW'(IN_H - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Frame mode latched on the first beat of each frame.
  always_ff @(posedge i_clk) begin
    if (i_rst)                       mode_q <= 1'b0;
    else if (i_feature_valid && first) mode_q <= i_avg_mode;
  end

  // Output strobes, one cycle after the completing beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_feature_valid <= 1'b0;
      o_frame_done    <= 1'b0;
    end else begin
      o_feature_valid <= emit;
      o_frame_done    <= emit && last_win;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    feature_pool_lane #(.DATA_W(DATA_W), .OUT_W(OUT_W), .LB_AW(LB_AW)) u_lane (
      .clk     (i_clk),
      .rst     (i_rst),
      .ld_even (ld_even),
      .pair    (pair),
      .odd_row (row[0]),
      .avg     (avg),
      .lb_idx  (lb_idx),
      .x       (i_features[g]),
      .y       (o_features[g])
    );
  end
endmodule

// File: tb/tb_feature_pool.sv
// Bench for feature_pool: a 28x28 instance and a 5x5 instance, driven with
// randomized frames and checked every cycle against a whole-image model.
module tb_feature_pool;
  localparam int NC = 6, DW = 8;
  localparam int W0 = 28, H0 = 28, W1 = 5, H1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, vld, avg;
  logic signed [DW-1:0] fin0 [0:NC-1];
  logic signed [DW-1:0] fin1 [0:NC-1];
  logic signed [DW-1:0] fo0  [0:NC-1];
  logic signed [DW-1:0] fo1  [0:NC-1];
  logic ov0, ov1, od0, od1;

  feature_pool #(.DATA_W(DW), .N_CH(NC), .IN_W(W0), .IN_H(H0)) dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_avg_mode(avg[0]), .i_feature_valid(vld[0]),
    .i_features(fin0), .o_feature_valid(ov0), .o_features(fo0), .o_frame_done(od0));

  feature_pool #(.DATA_W(DW), .N_CH(NC), .IN_W(W1), .IN_H(H1)) dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_avg_mode(avg[1]), .i_feature_valid(vld[1]),
    .i_features(fin1), .o_feature_valid(ov1), .o_features(fo1), .o_frame_done(od1));

  int pass_cnt = 0, tot_cnt = 0;
  bit chk_on = 0;

  task automatic check(input string nm, input int got, input int exp);
    tot_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  // ---------------- reference model ----------------
  int  img [2][H0][W0][NC];
  int  mrow[2], mcol[2];
  bit  fmode[2];
  bit  ev[2], ed[2];
  int  ef[2][NC];

  function automatic int floor_div4(input int s);
    int q;
    q = s / 4;
    if (s < 0 && (s % 4) != 0) q = q - 1;
    return q;
  endfunction

  always @(posedge clk) begin
    int w, h, r, c, s, mx;
    int smp[4];
    for (int k = 0; k < 2; k++) begin
      w = (k == 1) ? W1 : W0;
      h = (k == 1) ? H1 : H0;
      if (rst[k]) begin
        mrow[k] = 0; mcol[k] = 0; ev[k] = 0; ed[k] = 0;
        for (int ch = 0; ch < NC; ch++) ef[k][ch] = 0;
      end else begin
        ev[k] = 0; ed[k] = 0;
        if (vld[k]) begin
          r = mrow[k]; c = mcol[k];
          if (r == 0 && c == 0) fmode[k] = avg[k];
          for (int ch = 0; ch < NC; ch++) img[k][r][c][ch] = (k == 1) ? int'(fin1[ch]) : int'(fin0[ch]);
          if (r % 2 == 1 && c % 2 == 1 && r < 2 * (h / 2) && c < 2 * (w / 2)) begin
            for (int ch = 0; ch < NC; ch++) begin
              smp[0] = img[k][r-1][c-1][ch]; smp[1] = img[k][r-1][c][ch];
              smp[2] = img[k][r][c-1][ch];   smp[3] = img[k][r][c][ch];
              s = 0; mx = -100000;
              for (int i = 0; i < 4; i++) begin
                s += smp[i];
                if (smp[i] > mx) mx = smp[i];
              end
              ef[k][ch] = fmode[k] ? floor_div4(s) : mx;
            end
            ev[k] = 1;
            ed[k] = (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
          end
          mcol[k] = c + 1;
          if (mcol[k] == w) begin
            mcol[k] = 0;
            mrow[k] = (r + 1 == h) ? 0 : r + 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int ncnt[2];
  int outq[2][$];
  int doneq[2][$];

  always @(negedge clk) begin
    logic dv, dd;
    int df[NC];
    bit ok;
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        dv = (k == 1) ? ov1 : ov0;
        dd = (k == 1) ? od1 : od0;
        for (int ch = 0; ch < NC; ch++) df[ch] = (k == 1) ? int'(fo1[ch]) : int'(fo0[ch]);
        ok = (dv === ev[k]) && (dd === ed[k]);
        for (int ch = 0; ch < NC; ch++) if (df[ch] != ef[k][ch]) ok = 0;
        tot_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL cycle_cmp dut%0d t=%0t: valid %b/%b done %b/%b ch0 %0d/%0d ch5 %0d/%0d (got/expected)",
                      k, $time, dv, ev[k], dd, ed[k], df[0], ef[k][0], df[NC-1], ef[k][NC-1]);
        if (dv === 1'b1) begin
          ncnt[k]++;
          outq[k].push_back(df[0]);
          if (dd === 1'b1) doneq[k].push_back(ncnt[k]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int fb [2][H0][W0][NC];

  task automatic set_in(input int k, input logic v, input logic m, input int r, input int c, input bit junk);
    if (k == 1) begin vld[1] = v; avg[1] = m; end
    else        begin vld[0] = v; avg[0] = m; end
    for (int ch = 0; ch < NC; ch++) begin
      logic signed [DW-1:0] d;
      d = junk ? DW'($urandom) : DW'(fb[k][r][c][ch]);
      if (k == 1) fin1[ch] = d; else fin0[ch] = d;
    end
  endtask

  task automatic idle(input int k, input int n);
    repeat (n) begin
      @(negedge clk);
      set_in(k, 1'b0, 1'($urandom_range(1)), 0, 0, 1'b1);
    end
  endtask

  task automatic fill_ramp(input int k, input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        for (int ch = 0; ch < NC; ch++) fb[k][r][c][ch] = (r * w + c) % 100 - 50;
  endtask

  task automatic fill_rand(input int k, input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        for (int ch = 0; ch < NC; ch++) fb[k][r][c][ch] = int'($urandom_range(255)) - 128;
  endtask

  task automatic stream(input int k, input int w, input bit sm, input bit tog, input int gap_pct, input int nbeats);
    logic m;
    for (int p = 0; p < nbeats; p++) begin
      while (int'($urandom_range(99)) < gap_pct) idle(k, 1);
      m = (p == 0 || !tog) ? logic'(sm) : logic'($urandom_range(1));
      @(negedge clk);
      set_in(k, 1'b1, m, p / w, p % w, 1'b0);
    end
  endtask

  initial begin
    int b, d;
    rst = 2'b11; vld = 2'b00; avg = 2'b00;
    for (int ch = 0; ch < NC; ch++) begin fin0[ch] = '0; fin1[ch] = '0; end
    repeat (3) @(negedge clk);
    chk_on = 1;
    check("reset_valid", int'(ov0), 0);
    check("reset_done", int'(od1), 0);
    check("reset_feat", int'(fo0[3]), 0);
    @(negedge clk);
    rst = 2'b00;

    // Max mode ramp frame, defaults.
    fill_ramp(0, W0, H0);
    b = ncnt[0]; d = doneq[0].size();
    stream(0, W0, 1'b0, 1'b0, 0, W0 * H0);
    idle(0, 4);
    check("ramp_count", ncnt[0] - b, 196);
    check("ramp_first", outq[0][b], -21);
    check("ramp_done_cnt", doneq[0].size() - d, 1);

    // Average mode with pinned corner windows, random gaps.
    fill_rand(0, W0, H0);
    for (int ch = 0; ch < NC; ch++) begin
      fb[0][0][0][ch] = -1;   fb[0][0][1][ch] = -2;   fb[0][1][0][ch] = -1;   fb[0][1][1][ch] = -2;
      fb[0][0][2][ch] = 127;  fb[0][0][3][ch] = 127;  fb[0][1][2][ch] = 127;  fb[0][1][3][ch] = 127;
      fb[0][0][4][ch] = -128; fb[0][0][5][ch] = -128; fb[0][1][4][ch] = -128; fb[0][1][5][ch] = -127;
    end
    b = ncnt[0];
    stream(0, W0, 1'b1, 1'b0, 20, W0 * H0);
    idle(0, 4);
    check("avg_neg_floor", outq[0][b], -2);
    check("avg_pos_sat", outq[0][b+1], 127);
    check("avg_min", outq[0][b+2], -128);
    check("avg_count", ncnt[0] - b, 196);

    // Mode pin toggled mid-frame: avg frame, then max frame.
    fill_rand(0, W0, H0);
    stream(0, W0, 1'b1, 1'b1, 10, W0 * H0);
    idle(0, 3);
    fill_rand(0, W0, H0);
    b = ncnt[0];
    stream(0, W0, 1'b0, 1'b1, 10, W0 * H0);
    idle(0, 3);
    check("toggle_count", ncnt[0] - b, 196);

    // Reset after 40 beats, then a full frame.
    fill_rand(0, W0, H0);
    stream(0, W0, 1'b0, 1'b0, 0, 40);
    @(negedge clk); vld[0] = 1'b0; rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    idle(0, 2);
    b = ncnt[0]; d = doneq[0].size();
    fill_rand(0, W0, H0);
    stream(0, W0, 1'b1, 1'b0, 5, W0 * H0);
    idle(0, 4);
    check("post_reset_count", ncnt[0] - b, 196);
    check("post_reset_done", doneq[0].size() - d, 1);

    // Two frames back to back, distinct per-channel data.
    b = ncnt[0]; d = doneq[0].size();
    fill_rand(0, W0, H0);
    stream(0, W0, 1'b0, 1'b0, 0, W0 * H0);
    fill_rand(0, W0, H0);
    stream(0, W0, 1'b1, 1'b0, 0, W0 * H0);
    idle(0, 4);
    check("b2b_count", ncnt[0] - b, 392);
    check("b2b_done_cnt", doneq[0].size() - d, 2);
    if (doneq[0].size() - d == 2) begin
      check("b2b_done1", doneq[0][d] - b, 196);
      check("b2b_done2", doneq[0][d+1] - b, 392);
    end

    // 5x5 instance: odd edges ignored, heavy random gaps, both modes.
    for (int f = 0; f < 4; f++) begin
      fill_rand(1, W1, H1);
      b = ncnt[1]; d = doneq[1].size();
      stream(1, W1, 1'(f % 2), 1'b1, 40, W1 * H1);
      idle(1, 3);
      check("odd_count", ncnt[1] - b, 4);
      check("odd_done", doneq[1].size() - d, 1);
    end

    idle(1, 2);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/feature_pool.md
FEATURE_POOL -- requirements
Module: feature_pool

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: signed feature width in bits.
REQ-002 The block SHALL have parameter N_CH, default 6: number of channels processed in parallel.
REQ-003 The block SHALL have parameter IN_W, default 28: input map width in pixels (>=2).
REQ-004 The block SHALL have parameter IN_H, default 28: input map height in pixels (>=2).
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port i_avg_mode, input, 1 bit: 0 = max pool, 1 = average pool.
REQ-008 The block SHALL have port i_feature_valid, input, 1 bit: one pixel of all channels is present this cycle.
REQ-009 The block SHALL have port i_features[0:N_CH-1], input, DATA_W signed each: current pixel per channel.
REQ-010 The block SHALL have port o_feature_valid, output, 1 bit: one pooled pixel per channel is present this cycle.
REQ-011 The block SHALL have port o_features[0:N_CH-1], output, DATA_W signed each: pooled pixel per channel.
REQ-012 The block SHALL have port o_frame_done, output, 1 bit: pulses with the last pooled pixel of a frame.

Function
REQ-013 Input SHALL be raster order, row-major, IN_W*IN_H valid beats per frame; gaps (i_feature_valid=0) are allowed anywhere, and state SHALL hold during gaps.
REQ-014 The block SHALL pool 2x2 windows at stride 2, producing OUT_W=floor(IN_W/2) by OUT_H=floor(IN_H/2) outputs per channel.
REQ-015 With odd IN_W the last column, and with odd IN_H the last row, SHALL be consumed and counted but excluded from every window.
REQ-016 Column counter 0..IN_W-1 and row counter 0..IN_H-1 SHALL advance on valid beats only; col wraps to 0 and row increments at col=IN_W-1; both wrap to 0 after the last pixel of a frame.
REQ-017 Horizontal pair (even col c, odd col c+1) SHALL be reduced per channel; on even rows the partial SHALL be written to a per-channel line buffer of OUT_W entries indexed c/2.
REQ-018 On odd rows, the horizontal partial SHALL be combined with line-buffer entry c/2 to form the window result.
REQ-019 Max mode SHALL be the signed maximum of the four samples.
REQ-020 Avg mode SHALL form partials at DATA_W+2 bits, sum the four samples exactly, then arithmetic-shift right by 2 (floor toward -inf); the result always fits DATA_W.
REQ-021 i_avg_mode SHALL be sampled on the first valid beat of each frame (row=0, col=0) and held for that frame; mid-frame changes are ignored.
REQ-022 o_feature_valid SHALL assert exactly 1 cycle after the valid beat at (odd row, odd col) that completes a window, for one cycle, with o_features registered alongside.
REQ-023 o_features SHALL hold its last value when o_feature_valid=0.
REQ-024 o_frame_done SHALL assert in the same cycle as o_feature_valid for window (OUT_H-1, OUT_W-1) and be 0 otherwise.
REQ-025 Line-buffer contents from one frame SHALL NOT affect the next frame (even rows always overwrite before odd rows read).
REQ-026 Back-to-back frames with no gap SHALL be supported at one pixel per cycle.

Reset
REQ-027 While i_rst=1 at a clock edge, counters SHALL return to 0 and o_feature_valid, o_frame_done and all o_features SHALL become 0.
REQ-028 Reset mid-frame SHALL discard partial windows; the next valid beat after reset is pixel (0,0) of a new frame.
REQ-029 Line-buffer storage need not be reset.

Verification
REQ-030 Defaults, max mode, pixel value = (row*IN_W+col) mod 100 - 50 on all channels -> 196 outputs per frame, output (0,0) = max(-50,-49,-22,-21) = -21, o_frame_done once.
REQ-031 Avg mode, window samples {-1,-2,-1,-2} -> sum -6, output -2; window {127,127,127,127} -> 127; window {-128,-128,-128,-127} -> -128.
REQ-032 IN_W=5, IN_H=5, random gaps on i_feature_valid -> 4 outputs, column 4 and row 4 ignored, each output 1 cycle after its completing beat.
REQ-033 i_avg_mode toggled mid-frame -> whole frame uses mode sampled at pixel (0,0); next frame uses new value.
REQ-034 i_rst pulsed after 40 beats of a frame, then full frame streamed -> no output from discarded data, exactly 196 correct outputs.
REQ-035 Two frames back-to-back, N_CH=6 with distinct per-channel data -> 392 outputs, channels independent, frame_done on outputs 196 and 392.
